echo_delay: RTL and testbench

Stereo echo stage for the pedalboard audio path. It sits between the Audio_Controller capture side and the amplification/level-meter stage. It accepts one stereo sample per handshake and stores it in a circular buffer built from inferred block RAM. It returns the dry sample mixed with a delayed, attenuated copy, and regenerates the stored sample with feedback.

---
 rtl/echo_delay_if.sv | 34 +++
 rtl/echo_delay.sv | 223 ++++++++++++++++++++++
 tb/tb_echo_delay.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_delay_if.sv
// Stream interface of the stereo echo stage.
//
// Handshake rules, identical on both sides of the block:
// - A transfer happens on a rising clock edge where valid and ready are both 1.
// - The producer keeps valid and its data steady until that edge.
// - ready may depend combinationally on state but never on valid.
// Input side:  in_valid / in_ready carries in_left, in_right and the per-sample
//              controls delay_sel, fb_sel, bypass.
// Output side: out_valid / out_ready carries out_left, out_right.
interface echo_delay_if;
    logic        in_valid;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic        in_ready;
    logic [2:0]  delay_sel;
    logic [1:0]  fb_sel;
    logic        bypass;
    logic        out_valid;
    logic [31:0] out_left;
    logic [31:0] out_right;
    logic        out_ready;

    // Echo block side.
    modport slave (
        input  in_valid, in_left, in_right, delay_sel, fb_sel, bypass, out_ready,
        output in_ready, out_valid, out_left, out_right
    );

    // Surrounding audio path side (capture FIFO and consumer).
    modport master (
        output in_valid, in_left, in_right, delay_sel, fb_sel, bypass, out_ready,
        input  in_ready, out_valid, out_left, out_right
    );
endinterface

// File: rtl/echo_delay.sv
// Stereo echo stage: one stereo sample per handshake goes through a five-state
// sequence (IDLE, READ, CALC, WRITE, OUT). The dry sample is mixed with a delayed,
// halved copy from a circular buffer, and the buffer is refreshed with the dry
// sample plus an attenuated feedback copy. Both channels share one 64-bit RAM
// word (left in the upper half) and one write pointer.
module echo_delay #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    echo_delay_if.slave bus,
    output logic [2:0]  dbg_state
);

    // One delay step is an eighth of the buffer.
    localparam int              STEP     = DEPTH / 8;
    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);

    // Encoding is fixed so dbg_state has a stable meaning for checkers.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Handshake qualifiers.
    logic accept;
    logic mem_we;

    // Sample and controls captured at accept; nothing upstream can disturb them later.
    logic [31:0] x_left;
    logic [31:0] x_right;
    logic [2:0]  dsel;
    logic [1:0]  fsel;
    logic        byp;

    // Buffer bookkeeping. fill is one bit wider so it can hold DEPTH itself.
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   fill;
    logic [ADDR_W:0]   delay_len;
    logic [ADDR_W-1:0] rd_addr;

    // Circular buffer, read synchronously so it maps onto block RAM.
    logic [63:0] mem [DEPTH];
    logic [63:0] rd_data;

    // Delayed samples after fill gating, and the derived terms.
    logic signed [31:0] d_left;
    logic signed [31:0] d_right;
    logic signed [31:0] wet_left;
    logic signed [31:0] wet_right;
    logic signed [31:0] fb_left;
    logic signed [31:0] fb_right;
    logic [2:0]         fb_shift;
    logic [31:0]        mix_left;
    logic [31:0]        mix_right;
    logic [31:0]        regen_left;
    logic [31:0]        regen_right;

    // Registered results.
    logic [31:0] out_left_q;
    logic [31:0] out_right_q;
    logic [31:0] st_left;
    logic [31:0] st_right;

    // Signed 32-bit add evaluated at 33 bits and clamped to the 32-bit range.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        logic [31:0] res;
        sum = {a[31], a} + {b[31], b};
        if (sum[32] == sum[31]) begin
            res = sum[31:0];
        end else if (sum[32]) begin
            res = 32'h8000_0000;
        end else begin
            res = 32'h7FFF_FFFF;
        end
        return res;
    endfunction

    // in_ready is held low while reset is applied so the upstream FIFO never pops
    // a sample that the block would throw away.
    assign bus.in_ready  = (state == IDLE) && resetn;
    assign accept        = bus.in_ready && bus.in_valid;
    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign dbg_state     = state;

    // State register; reset abandons any sample in flight.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_next    = state;
        bus.out_valid = 1'b0;
        mem_we        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = CALC;
            end
            CALC: begin
                state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the sample and its controls on the accepting edge.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            x_left  <= bus.in_left;
            x_right <= bus.in_right;
            dsel    <= bus.delay_sel;
            fsel    <= bus.fb_sel;
            byp     <= bus.bypass;
        end
    end

    // Read address trails the write pointer by the selected delay. A full-length
    // delay truncates to 0 here and reads the slot about to be overwritten, which
    // holds the sample written exactly DEPTH accepts ago.
    always_comb begin
        delay_len = (ADDR_W + 1)'((int'(dsel) + 1) * STEP);
        rd_addr   = wr_ptr - delay_len[ADDR_W-1:0];
    end

    // Buffer port: write the regenerated pair in WRITE, read every cycle so the
    // word addressed during READ is available throughout CALC.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[wr_ptr] <= {st_left, st_right};
        end
        rd_data <= mem[rd_addr];
    end

    // Advance the write pointer and the saturating fill count once per sample.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (state == WRITE) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fill != FILL_MAX) begin
                fill <= fill + (ADDR_W + 1)'(1);
            end
        end
    end

    // Echo arithmetic. Until enough samples have been written to cover the delay
    // the delayed term is zero, so RAM contents left over from before reset stay silent.
    always_comb begin
        if (fill < delay_len) begin
            d_left  = '0;
            d_right = '0;
        end else begin
            d_left  = rd_data[63:32];
            d_right = rd_data[31:0];
        end
        // Widened before the +1 so fb_sel=3 gives a shift of 4, not 0.
        fb_shift  = {1'b0, fsel} + 3'd1;
        wet_left  = d_left >>> 1;
        wet_right = d_right >>> 1;
        fb_left   = d_left >>> fb_shift;
        fb_right  = d_right >>> fb_shift;
        if (byp) begin
            mix_left    = x_left;
            mix_right   = x_right;
            regen_left  = x_left;
            regen_right = x_right;
        end else begin
            mix_left    = sat_add(x_left, wet_left);
            mix_right   = sat_add(x_right, wet_right);
            regen_left  = sat_add(x_left, fb_left);
            regen_right = sat_add(x_right, fb_right);
        end
    end

    // Results are registered in CALC only, so the outputs hold their last value
    // through OUT and beyond.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            out_left_q  <= '0;
            out_right_q <= '0;
            st_left     <= '0;
            st_right    <= '0;
        end else if (state == CALC) begin
            out_left_q  <= mix_left;
            out_right_q <= mix_right;
            st_left     <= regen_left;
            st_right    <= regen_right;
        end
    end

endmodule

// File: tb/tb_echo_delay.sv
// Bench for echo_delay: directed scenarios plus a randomized stream, every
// output compared against a sample-history model of the echo rules.
module tb_echo_delay;

    localparam int         DEPTH   = 8192;
    localparam int         ADDR_W  = 13;
    localparam int         HIST    = 2 * DEPTH;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd2;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected {left, right} per accepted sample, in order.
    logic [63:0] exp_q[$];

    // Model state: what was stored for every accepted sample since reset.
    logic [31:0] hist_l [HIST];
    logic [31:0] hist_r [HIST];
    int          n_acc = 0;

    echo_delay_if bus();

    echo_delay #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] clamp32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return 32'(v);
    endfunction

    // x plus d divided by 2**sh (rounded toward minus infinity), clamped.
    function automatic logic [31:0] add_scaled(input logic [31:0] x, input logic [31:0] d, input int sh);
        longint xv;
        longint dv;
        xv = longint'($signed(x));
        dv = longint'($signed(d));
        return clamp32(xv + (dv >>> sh));
    endfunction

    task automatic model_reset();
        n_acc = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] l, input logic [31:0] r,
                                input logic [2:0] ds, input logic [1:0] fs, input logic bp);
        int          dlen;
        logic [31:0] dl, dr, ol, orr, sl, sr;
        dlen = (int'(ds) + 1) * (DEPTH / 8);
        if (n_acc >= dlen) begin
            dl = hist_l[(n_acc - dlen) % HIST];
            dr = hist_r[(n_acc - dlen) % HIST];
        end else begin
            dl = 32'h0;
            dr = 32'h0;
        end
        if (bp) begin
            ol = l;  orr = r;  sl = l;  sr = r;
        end else begin
            ol  = add_scaled(l, dl, 1);
            orr = add_scaled(r, dr, 1);
            sl  = add_scaled(l, dl, int'(fs) + 1);
            sr  = add_scaled(r, dr, int'(fs) + 1);
        end
        hist_l[n_acc % HIST] = sl;
        hist_r[n_acc % HIST] = sr;
        n_acc++;
        exp_q.push_back({ol, orr});
    endtask

    function automatic logic [31:0] rand_sample();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 1) == 0) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // One full sample transaction; hold>0 stalls the consumer for that many cycles.
    task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [2:0] ds,
                        input logic [1:0] fs, input logic bp, input int hold,
                        output logic [31:0] ol, output logic [31:0] orr);
        int          waited;
        int          lat;
        logic [63:0] exp;
        @(negedge clk);
        bus.in_left   = l;
        bus.in_right  = r;
        bus.delay_sel = ds;
        bus.fb_sel    = fs;
        bus.bypass    = bp;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check32("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
        model_accept(l, r, ds, fs, bp);
        @(posedge clk);
        #1;
        // Scramble everything after accept; the sample in flight must not notice.
        bus.in_valid  = 1'b0;
        bus.in_left   = $urandom();
        bus.in_right  = $urandom();
        bus.delay_sel = 3'($urandom_range(0, 7));
        bus.fb_sel    = 2'($urandom_range(0, 3));
        bus.bypass    = 1'($urandom_range(0, 1));
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check32("latency", lat, 32'd4);
        exp = exp_q.pop_front();
        ol  = bus.out_left;
        orr = bus.out_right;
        check32("out_left", ol, exp[63:32]);
        check32("out_right", orr, exp[31:0]);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                bus.in_left  = $urandom();
                @(negedge clk);
                check32("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
                check32("hold_out_left", bus.out_left, ol);
                check32("hold_out_right", bus.out_right, orr);
                check32("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            end
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b0;
            @(negedge clk);
            check32("post_hs_out_valid", {31'b0, bus.out_valid}, 32'd0);
            check32("post_hs_in_ready", {31'b0, bus.in_ready}, 32'd1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ol, orr;

        resetn        = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_left   = 32'h1111_1111;
        bus.in_right  = 32'h2222_2222;
        bus.delay_sel = 3'd0;
        bus.fb_sel    = 2'd0;
        bus.bypass    = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset held 3 cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check32("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            check32("rst_out_left", bus.out_left, 32'h0);
            check32("rst_out_right", bus.out_right, 32'h0);
            check32("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        end
        bus.in_valid = 1'b0;
        resetn       = 1'b1;
        @(negedge clk);
        check32("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check32("rel_no_accept", {31'b0, bus.out_valid}, 32'd0);
        end

        // Impulse through the shortest delay.
        apply_reset();
        for (int i = 0; i <= 2048; i++) begin
            send((i == 0) ? 32'h4000_0000 : 32'h0, (i == 0) ? 32'hC000_0000 : 32'h0,
                 3'd0, 2'd0, 1'b0, 0, ol, orr);
            if (i == 0) begin
                check32("imp0_l", ol, 32'h4000_0000);
                check32("imp0_r", orr, 32'hC000_0000);
            end
            if (i == 1023) check32("imp1023_l", ol, 32'h0);
            if (i == 1024) begin
                check32("imp1024_l", ol, 32'h2000_0000);
                check32("imp1024_r", orr, 32'hE000_0000);
            end
            if (i == 2048) begin
                check32("imp2048_l", ol, 32'h1000_0000);
                check32("imp2048_r", orr, 32'hF000_0000);
            end
        end

        // Longest delay: fill gating over a full buffer, then the wrap.
        apply_reset();
        for (int i = 0; i <= 8192; i++) begin
            send(32'd5, 32'hFFFF_FFFB, 3'd7, 2'd3, 1'b0, 0, ol, orr);
            if (i == 8191) begin
                check32("wrap8191_l", ol, 32'd5);
                check32("wrap8191_r", orr, 32'hFFFF_FFFB);
            end
            if (i == 8192) begin
                check32("wrap8192_l", ol, 32'd7);
                check32("wrap8192_r", orr, 32'hFFFF_FFF8);
            end
        end

        // Bypass with a populated buffer.
        send(32'h0000_1234, 32'h0000_5678, 3'd0, 2'd0, 1'b1, 0, ol, orr);
        check32("bypass_l", ol, 32'h0000_1234);
        check32("bypass_r", orr, 32'h0000_5678);

        // Backpressure: 20 stalled cycles; delayed term is the stored 5 / -5.
        send(32'd100, 32'hFFFF_FF9C, 3'd0, 2'd0, 1'b0, 20, ol, orr);
        check32("bp_l", ol, 32'd102);
        check32("bp_r", orr, 32'hFFFF_FF99);

        // Reset while a sample sits in CALC.
        @(negedge clk);
        bus.in_left   = 32'h00AB_CDEF;
        bus.in_right  = 32'h0012_3456;
        bus.delay_sel = 3'd0;
        bus.fb_sel    = 2'd0;
        bus.bypass    = 1'b0;
        bus.in_valid  = 1'b1;
        check32("midop_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("midop_in_calc", {29'b0, dbg_state}, {29'b0, ST_CALC});
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check32("midop_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check32("midop_no_out", {31'b0, bus.out_valid}, 32'd0);
        end
        send(32'd9, 32'hFFFF_FFF7, 3'd0, 2'd0, 1'b0, 0, ol, orr);
        check32("midop_first_l", ol, 32'd9);
        check32("midop_first_r", orr, 32'hFFFF_FFF7);

        // Saturation at both rails, 1024 samples apart.
        apply_reset();
        for (int i = 0; i <= 1024; i++) begin
            send((i % 1024 == 0) ? 32'h7FFF_FFF0 : 32'h0, (i % 1024 == 0) ? 32'h8000_0010 : 32'h0,
                 3'd0, 2'd0, 1'b0, 0, ol, orr);
            if (i == 1024) begin
                check32("sat_pos", ol, 32'h7FFF_FFFF);
                check32("sat_neg", orr, 32'h8000_0000);
            end
        end

        // Randomized stream: random data, delays, feedback, bypass and stalls.
        for (int i = 0; i < 1000; i++) begin
            send(rand_sample(), rand_sample(), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0,
                 ol, orr);
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
